rs_keysolve: RTL and testbench

- Key-equation solver for the t=2 RS(GF(2^8)) decoder; sits directly downstream of the syndrome stage.
- On each syndrome-ready pulse, captures s0..s3 and computes the error-locator Lambda(x)=1+L1·x+L2·x^2 by direct Peterson solution. Uses one shared GF multiplier, one squarer, and Fermat inversion.
- Results feed the downstream Chien/Forney correction stage.

---
 rtl/rs_pkg.sv | 36 +++
 rtl/Square.sv | 18 +
 rtl/mul.sv | 20 ++
 rtl/rs_gfinv.sv | 67 ++++++
 rtl/rs_keysolve.sv | 207 ++++++++++++++++++++
 tb/tb_rs_keysolve.sv | 270 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/rs_pkg.sv
// Shared definitions for the t=2 RS(GF(2^8)) decoder: field parameters, solver
// state encoding, error-count codes and the GF polynomial reduction helper.
package rs_pkg;

  localparam int unsigned     SYMW    = 8;
  localparam logic [SYMW:0]   GF_POLY = 9'h11D;
  localparam int unsigned     LATENCY = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAP,
    S_PROD,
    S_DEN,
    S_INV,
    S_SOL,
    S_DONE
  } ks_state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_ONE  = 2'd1,
    ERR_TWO  = 2'd2,
    ERR_FAIL = 2'd3
  } err_e;

  // Reduce a carry-less product of two symbols modulo GF_POLY.
  function automatic logic [SYMW-1:0] gf_reduce(input logic [2*SYMW-2:0] v);
    logic [2*SYMW-2:0] r;
    r = v;
    for (int unsigned i = 2*SYMW-2; i >= SYMW; i--) begin
      if (r[i]) r[i -: SYMW+1] = r[i -: SYMW+1] ^ GF_POLY;
    end
    return r[SYMW-1:0];
  endfunction

endpackage

// File: rtl/Square.sv
// Combinational GF(2^8) squarer.
module Square
  import rs_pkg::*;
(
  input  logic [SYMW-1:0] a_i,
  output logic [SYMW-1:0] y_o
);

  logic [2*SYMW-2:0] spread;

  // Squaring is linear over GF(2): bit i of the input lands on bit 2i before reduction.
  always_comb begin
    spread = '0;
    for (int unsigned i = 0; i < SYMW; i++) spread[2*i] = a_i[i];
    y_o = gf_reduce(spread);
  end

endmodule

// File: rtl/mul.sv
// Combinational GF(2^8) multiplier: carry-less product followed by reduction.
module mul
  import rs_pkg::*;
(
  input  logic [SYMW-1:0] a_i,
  input  logic [SYMW-1:0] b_i,
  output logic [SYMW-1:0] p_o
);

  logic [2*SYMW-2:0] prod;

  always_comb begin
    prod = '0;
    for (int unsigned i = 0; i < SYMW; i++) begin
      if (b_i[i]) prod = prod ^ ({{(SYMW-1){1'b0}}, a_i} << i);
    end
    p_o = gf_reduce(prod);
  end

endmodule

// File: rtl/rs_gfinv.sv
// Sequential Fermat inverter (x^254): start latches x, seven steps follow on the
// shared squarer/multiplier, done_o marks the last step; inv_o is valid afterwards.
module rs_gfinv
  import rs_pkg::*;
(
  input  logic            clk,
  input  logic            clr_i,
  input  logic            start_i,
  input  logic [SYMW-1:0] x_i,
  input  logic [SYMW-1:0] sq_y_i,
  input  logic [SYMW-1:0] mul_p_i,
  output logic [SYMW-1:0] sq_a_o,
  output logic [SYMW-1:0] mul_a_o,
  output logic [SYMW-1:0] mul_b_o,
  output logic [SYMW-1:0] inv_o,
  output logic            done_o
);

  logic [2:0]      step_q, step_d;
  logic [SYMW-1:0] x_q, x_d, p_q, p_d, acc_q, acc_d;

  // acc accumulates x^(2+4+...+2^k); a zero input naturally yields a zero result.
  always_comb begin
    x_d     = x_q;
    p_d     = p_q;
    acc_d   = acc_q;
    step_d  = step_q;
    done_o  = 1'b0;
    sq_a_o  = (step_q == 3'd1) ? x_q : p_q;
    mul_a_o = acc_q;
    mul_b_o = sq_y_i;
    if (start_i) begin
      x_d    = x_i;
      step_d = 3'd1;
    end else if (step_q == 3'd1) begin
      p_d    = sq_y_i;
      acc_d  = sq_y_i;
      step_d = 3'd2;
    end else if (step_q != 3'd0) begin
      p_d   = sq_y_i;
      acc_d = mul_p_i;
      if (step_q == 3'd7) begin
        step_d = '0;
        done_o = 1'b1;
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      step_q <= '0;
      x_q    <= '0;
      p_q    <= '0;
      acc_q  <= '0;
    end else begin
      step_q <= step_d;
      x_q    <= x_d;
      p_q    <= p_d;
      acc_q  <= acc_d;
    end
  end

  assign inv_o = acc_q;

endmodule

// File: rtl/rs_keysolve.sv
// t=2 RS key-equation solver (direct Peterson) on one shared multiplier and squarer.
// Define RS_KEYSOLVE_STATS_EN to add saturating corrCnt/failCnt block counters.
module rs_keysolve
  import rs_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            running,
  input  logic            synReady,
  input  logic [SYMW-1:0] s0,
  input  logic [SYMW-1:0] s1,
  input  logic [SYMW-1:0] s2,
  input  logic [SYMW-1:0] s3,
  output logic [SYMW-1:0] lambda1,
  output logic [SYMW-1:0] lambda2,
  output logic [1:0]      errCnt,
  output logic            uncorrectable,
  output logic            keyReady,
  output logic            busy,
`ifdef RS_KEYSOLVE_STATS_EN
  output logic [15:0]     corrCnt,
  output logic [15:0]     failCnt,
`endif
  output logic            overrun
);

  ks_state_e       state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            clr;
  logic [SYMW-1:0] s0_q, s1_q, s2_q, s3_q;
  logic [SYMW-1:0] s1s2_q, s0s3_q, s1s3_q, s0s2_q, s1sq_q, s2sq_q, l1_q;
  logic [SYMW-1:0] d, n1, n2, divisor;
  logic [SYMW-1:0] mul_a, mul_b, mul_p, sq_a, sq_y;
  logic [SYMW-1:0] inv_sq_a, inv_mul_a, inv_mul_b, inv;
  logic            inv_done;
  logic [SYMW-1:0] l1_fin, l2_fin, lambda1_q, lambda2_q;
  err_e            err_fin, err_q;
  logic            overrun_q;

  assign clr     = reset | ~running;
  assign d       = s1sq_q ^ s0s2_q;
  assign n1      = s1s2_q ^ s0s3_q;
  assign n2      = s2sq_q ^ s1s3_q;
  assign divisor = (d != '0) ? d : s0_q;

  mul    u_mul (.a_i(mul_a), .b_i(mul_b), .p_o(mul_p));
  Square u_sq  (.a_i(sq_a), .y_o(sq_y));

  rs_gfinv u_inv (
    .clk    (clk),
    .clr_i  (clr),
    .start_i(state_q == S_DEN),
    .x_i    (divisor),
    .sq_y_i (sq_y),
    .mul_p_i(mul_p),
    .sq_a_o (inv_sq_a),
    .mul_a_o(inv_mul_a),
    .mul_b_o(inv_mul_b),
    .inv_o  (inv),
    .done_o (inv_done)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (synReady) state_d = S_CAP;
      S_CAP: begin
        state_d = S_PROD;
        cnt_d   = '0;
      end
      S_PROD: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = S_DEN;
      end
      S_DEN:  state_d = S_INV;
      S_INV:  if (inv_done) state_d = S_SOL;
      S_SOL: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Shared-operator schedule: products in PROD, inverter steps in INV, L1 then L2 in SOL.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    sq_a  = '0;
    case (state_q)
      S_PROD: begin
        sq_a = cnt_q[0] ? s2_q : s1_q;
        case (cnt_q)
          2'd0:    begin mul_a = s1_q; mul_b = s2_q; end
          2'd1:    begin mul_a = s0_q; mul_b = s3_q; end
          2'd2:    begin mul_a = s1_q; mul_b = s3_q; end
          default: begin mul_a = s0_q; mul_b = s2_q; end
        endcase
      end
      S_INV: begin
        sq_a  = inv_sq_a;
        mul_a = inv_mul_a;
        mul_b = inv_mul_b;
      end
      S_SOL: begin
        mul_b = inv;
        if (d != '0) mul_a = cnt_q[0] ? n2 : n1;
        else         mul_a = cnt_q[0] ? '0 : s1_q;
      end
      default: ;
    endcase
  end

  // Classification on the second SOL cycle, where mul_p carries L2.
  always_comb begin
    l1_fin  = '0;
    l2_fin  = '0;
    err_fin = ERR_FAIL;
    if ((s0_q | s1_q | s2_q | s3_q) == '0) begin
      err_fin = ERR_NONE;
    end else if (d != '0) begin
      if (mul_p != '0) begin
        err_fin = ERR_TWO;
        l1_fin  = l1_q;
        l2_fin  = mul_p;
      end
    end else if (s0_q != '0 && s2sq_q == s1s3_q) begin
      err_fin = ERR_ONE;
      l1_fin  = l1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      lambda1_q <= '0;
      lambda2_q <= '0;
      err_q     <= ERR_NONE;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= synReady && (state_q != S_IDLE);
      if (state_q == S_IDLE && synReady) begin
        s0_q <= s0;
        s1_q <= s1;
        s2_q <= s2;
        s3_q <= s3;
      end
      if (state_q == S_PROD) begin
        case (cnt_q)
          2'd0:    begin s1s2_q <= mul_p; s1sq_q <= sq_y; end
          2'd1:    begin s0s3_q <= mul_p; s2sq_q <= sq_y; end
          2'd2:    s1s3_q <= mul_p;
          default: s0s2_q <= mul_p;
        endcase
      end
      if (state_q == S_SOL) begin
        if (cnt_q[0]) begin
          lambda1_q <= l1_fin;
          lambda2_q <= l2_fin;
          err_q     <= err_fin;
        end else begin
          l1_q <= mul_p;
        end
      end
    end
  end

`ifdef RS_KEYSOLVE_STATS_EN
  logic [15:0] corr_q, fail_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      corr_q <= '0;
      fail_q <= '0;
    end else if (state_q == S_DONE) begin
      if ((err_q == ERR_ONE || err_q == ERR_TWO) && corr_q != '1) corr_q <= corr_q + 16'd1;
      if (err_q == ERR_FAIL && fail_q != '1) fail_q <= fail_q + 16'd1;
    end
  end

  assign corrCnt = corr_q;
  assign failCnt = fail_q;
`endif

  assign lambda1       = lambda1_q;
  assign lambda2       = lambda2_q;
  assign errCnt        = err_q;
  assign uncorrectable = (err_q == ERR_FAIL);
  assign keyReady      = (state_q == S_DONE);
  assign busy          = (state_q != S_IDLE);
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_rs_keysolve.sv
// Bench for rs_keysolve: cycle-level Peterson reference model (field division by
// exhaustive inverse search) compared every cycle, plus literal directed cases.
module tb_rs_keysolve;

  localparam int LAT = 16;

  logic       clk = 1'b0;
  logic       reset, running, synReady;
  logic [7:0] s0, s1, s2, s3;
  logic [7:0] lambda1, lambda2;
  logic [1:0] errCnt;
  logic       uncorrectable, keyReady, busy, overrun;

  rs_keysolve dut (
    .clk          (clk),
    .reset        (reset),
    .running      (running),
    .synReady     (synReady),
    .s0           (s0),
    .s1           (s1),
    .s2           (s2),
    .s3           (s3),
    .lambda1      (lambda1),
    .lambda2      (lambda2),
    .errCnt       (errCnt),
    .uncorrectable(uncorrectable),
    .keyReady     (keyReady),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] gpow(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < n; i++) r = gmul(r, x);
    return r;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    for (int i = 1; i < 256; i++) if (gmul(a, 8'(i)) == 8'h01) return 8'(i);
    return 8'h00;
  endfunction

  task automatic peterson(input logic [7:0] a, b, c, e,
                          output logic [7:0] l1, output logic [7:0] l2, output logic [1:0] err);
    logic [7:0] dd, x1, x2;
    l1  = 8'h00;
    l2  = 8'h00;
    err = 2'd3;
    dd  = gmul(b, b) ^ gmul(a, c);
    if ((a | b | c | e) == 8'h00) begin
      err = 2'd0;
    end else if (dd != 8'h00) begin
      x1 = gmul(gmul(b, c) ^ gmul(a, e), ginv(dd));
      x2 = gmul(gmul(c, c) ^ gmul(b, e), ginv(dd));
      if (x2 != 8'h00) begin
        err = 2'd2;
        l1  = x1;
        l2  = x2;
      end
    end else if (a != 8'h00 && gmul(c, c) == gmul(b, e)) begin
      err = 2'd1;
      l1  = gmul(b, ginv(a));
    end
  endtask

  // Reference model state: pos counts cycles since the capture edge.
  bit         m_busy = 0;
  int         m_pos  = 0;
  logic [7:0] r_l1, r_l2;
  logic [1:0] r_err;
  logic       exp_key = 0, exp_busy = 0, exp_ovr = 0;
  logic [7:0] exp_l1 = 0, exp_l2 = 0;
  logic [1:0] exp_err = 0;

  task automatic model_update();
    if (reset || !running) begin
      m_busy  = 0;
      m_pos   = 0;
      exp_ovr = 0;
      exp_l1  = 8'h00;
      exp_l2  = 8'h00;
      exp_err = 2'd0;
    end else begin
      exp_ovr = synReady && m_busy;
      if (m_busy) begin
        m_pos++;
        if (m_pos > LAT) m_busy = 0;
      end else if (synReady) begin
        m_busy = 1;
        m_pos  = 1;
        peterson(s0, s1, s2, s3, r_l1, r_l2, r_err);
      end
      if (m_busy && m_pos == LAT) begin
        exp_l1  = r_l1;
        exp_l2  = r_l2;
        exp_err = r_err;
      end
    end
    exp_busy = m_busy;
    exp_key  = m_busy && (m_pos == LAT);
  endtask

  always @(negedge clk) begin
    check("keyReady", {15'd0, keyReady}, {15'd0, exp_key});
    check("busy", {15'd0, busy}, {15'd0, exp_busy});
    check("overrun", {15'd0, overrun}, {15'd0, exp_ovr});
    check("lambda1", {8'd0, lambda1}, {8'd0, exp_l1});
    check("lambda2", {8'd0, lambda2}, {8'd0, exp_l2});
    check("errCnt", {14'd0, errCnt}, {14'd0, exp_err});
    check("uncorrectable", {15'd0, uncorrectable}, {15'd0, exp_err == 2'd3});
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_syn(input logic [31:0] v);
    {s0, s1, s2, s3} = v;
  endtask

  task automatic set_rand();
    {s0, s1, s2, s3} = $urandom;
  endtask

  task automatic solve_lit(input string name, input logic [31:0] v,
                           input logic [7:0] l1, input logic [7:0] l2, input logic [1:0] err);
    synReady = 1'b1;
    set_syn(v);
    tick();
    synReady = 1'b0;
    set_rand();
    repeat (LAT - 1) tick();
    check({name, "_key"}, {15'd0, keyReady}, 16'd1);
    check({name, "_l1"}, {8'd0, lambda1}, {8'd0, l1});
    check({name, "_l2"}, {8'd0, lambda2}, {8'd0, l2});
    check({name, "_err"}, {14'd0, errCnt}, {14'd0, err});
    check({name, "_unc"}, {15'd0, uncorrectable}, {15'd0, err == 2'd3});
    tick();
  endtask

  task automatic abort_test(input string name, input bit use_reset);
    synReady = 1'b1;
    set_syn(32'h00030509);
    tick();
    synReady = 1'b0;
    repeat (7) tick();
    if (use_reset) reset = 1'b1;
    else running = 1'b0;
    tick();
    reset   = 1'b0;
    running = 1'b1;
    check({name, "_busy"}, {15'd0, busy}, 16'd0);
    check({name, "_key"}, {15'd0, keyReady}, 16'd0);
    check({name, "_l1"}, {8'd0, lambda1}, 16'd0);
    check({name, "_l2"}, {8'd0, lambda2}, 16'd0);
    check({name, "_err"}, {14'd0, errCnt}, 16'd0);
    repeat (12) tick();
  endtask

  task automatic gen_syn();
    int         kind;
    logic [7:0] x, y;
    kind = $urandom_range(0, 4);
    {s0, s1, s2, s3} = 32'h0;
    if (kind == 4) begin
      set_rand();
    end else begin
      for (int k = 0; k < kind; k++) begin
        x  = gpow(8'h02, $urandom_range(0, 254));
        y  = 8'($urandom_range(1, 255));
        s0 = s0 ^ y;
        s1 = s1 ^ gmul(y, x);
        s2 = s2 ^ gmul(y, gmul(x, x));
        s3 = s3 ^ gmul(y, gpow(x, 3));
      end
    end
  endtask

  initial begin
    int r;
    reset    = 1'b1;
    running  = 1'b0;
    synReady = 1'b0;
    set_syn(32'h0);
    repeat (3) tick();
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_l1", {8'd0, lambda1}, 16'd0);
    reset   = 1'b0;
    running = 1'b1;
    tick();

    solve_lit("zero", 32'h00000000, 8'h00, 8'h00, 2'd0);
    solve_lit("one", 32'h01020408, 8'h02, 8'h00, 2'd1);
    solve_lit("two", 32'h00030509, 8'h03, 8'h02, 2'd2);
    solve_lit("failA", 32'h01020409, 8'h00, 8'h00, 2'd3);
    solve_lit("failB", 32'h00000001, 8'h00, 8'h00, 2'd3);

    for (int c = 0; c <= 34; c++) begin
      synReady = (c == 0 || c == 5 || c == 16 || c == 17);
      if (c == 0) set_syn(32'h01020408);
      else if (c == 5) set_syn(32'h00000001);
      else if (c == 17) set_syn(32'h00030509);
      else set_rand();
      tick();
      synReady = 1'b0;
      if (c == 5) check("ovr_at6", {15'd0, overrun}, 16'd1);
      if (c == 15) begin
        check("ovr_first_key", {15'd0, keyReady}, 16'd1);
        check("ovr_first_l1", {8'd0, lambda1}, 16'h0002);
        check("ovr_first_err", {14'd0, errCnt}, 16'd1);
      end
      if (c == 16) check("ovr_at17", {15'd0, overrun}, 16'd1);
      if (c == 32) begin
        check("ovr_second_key", {15'd0, keyReady}, 16'd1);
        check("ovr_second_l1", {8'd0, lambda1}, 16'h0003);
        check("ovr_second_l2", {8'd0, lambda2}, 16'h0002);
        check("ovr_second_err", {14'd0, errCnt}, 16'd2);
      end
    end

    solve_lit("pre_rst", 32'h00030509, 8'h03, 8'h02, 2'd2);
    abort_test("abort_rst", 1'b1);
    solve_lit("post_rst", 32'h00030509, 8'h03, 8'h02, 2'd2);
    abort_test("abort_run", 1'b0);
    solve_lit("post_run", 32'h01020408, 8'h02, 8'h00, 2'd1);

    for (int c = 0; c < 1500; c++) begin
      r        = $urandom_range(0, 199);
      reset    = (r == 0);
      running  = (r != 1);
      synReady = ($urandom_range(0, 3) == 0);
      if (synReady) gen_syn();
      else set_rand();
      tick();
    end
    reset    = 1'b0;
    running  = 1'b1;
    synReady = 1'b0;
    repeat (LAT + 4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
